// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - two-read sequencer over a single-port register file with write snooping
module operand_fetch #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_rs1,
  input  logic [ADDR_WIDTH-1:0] req_rs2,
  input  logic                  req_use_rs2,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic [ADDR_WIDTH-1:0] rf_read_addr,
  input  logic [DATA_WIDTH-1:0] rf_dout,
  input  logic                  rf_we,
  input  logic [ADDR_WIDTH-1:0] rf_write_addr,
  input  logic [DATA_WIDTH-1:0] rf_din
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT1 = 2'd1;
  localparam logic [1:0] S_WAIT2 = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] rs1_q;
  logic [ADDR_WIDTH-1:0] rs2_q;
  logic                  use_q;
  logic                  accept;
  logic                  hit1;
  logic                  hit2;
  logic [DATA_WIDTH-1:0] val1;
  logic [DATA_WIDTH-1:0] val2;

  assign op_valid  = (state == S_OUT);
  assign req_ready = !flush && ((state == S_IDLE) || ((state == S_OUT) && op_ready));
  assign accept    = req_valid && req_ready;

  // A write to x0 never hits: x0 is forced to zero regardless of what the regfile holds
  assign hit1 = rf_we && (rf_write_addr == rs1_q) && (rs1_q != '0);
  assign hit2 = rf_we && (rf_write_addr == rs2_q) && (rs2_q != '0);
  assign val1 = (rs1_q == '0) ? '0 : (hit1 ? rf_din : rf_dout);
  assign val2 = (rs2_q == '0) ? '0 : (hit2 ? rf_din : rf_dout);

  // Read address: rs1 is issued while idle/handing off so its data lands in WAIT1
  always_comb begin
    rf_read_addr = req_rs1;
    if ((state == S_WAIT1) || (state == S_WAIT2)) rf_read_addr = rs2_q;
  end

  // Sequencing state and latched request fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      rs1_q <= '0;
      rs2_q <= '0;
      use_q <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (accept) state <= S_WAIT1;
        S_WAIT1: state <= use_q ? S_WAIT2 : S_OUT;
        S_WAIT2: state <= S_OUT;
        default: begin
          if (accept) state <= S_WAIT1;
          else if (op_ready) state <= S_IDLE;
        end
      endcase
      if (accept) begin
        rs1_q <= req_rs1;
        rs2_q <= req_rs2;
        use_q <= req_use_rs2;
      end
    end
  end

  // Operand capture from the read port, plus snoop refresh of operands already held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a <= '0;
      op_b <= '0;
    end else if (!flush) begin
      case (state)
        S_WAIT1: begin
          op_a <= val1;
          if (!use_q) op_b <= '0;
        end
        S_WAIT2: begin
          op_b <= val2;
          if (hit1) op_a <= rf_din;
        end
        S_OUT: begin
          if (hit1) op_a <= rf_din;
          if (use_q && hit2) op_b <= rf_din;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - scoreboard bench for operand_fetch with a behavioural register file
module tb_operand_fetch;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_rs1;
  logic [AW-1:0] req_rs2;
  logic          req_use_rs2;
  logic          op_valid;
  logic          op_ready;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [AW-1:0] rf_read_addr;
  logic [DW-1:0] rf_dout;
  logic          rf_we;
  logic [AW-1:0] rf_write_addr;
  logic [DW-1:0] rf_din;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] rf_mem [32];
  logic [DW-1:0] ref_mem [32];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;

  operand_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_use_rs2(req_use_rs2),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .rf_read_addr(rf_read_addr), .rf_dout(rf_dout),
    .rf_we(rf_we), .rf_write_addr(rf_write_addr), .rf_din(rf_din)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Register file: sync read, one-cycle latency, write-to-read bypass, x0 stored like any other
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_write_addr] <= rf_din;
    rf_dout <= (rf_we && rf_write_addr == rf_read_addr) ? rf_din : rf_mem[rf_read_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Operand handshake: pop the oldest expected pair and compare
  always @(negedge clk) begin
    if (!rst && op_valid && op_ready && !flush) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("op_a", op_a, e.a);
        check("op_b", op_b, e.b);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t exp_of(input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic u);
    exp_t e;
    e.a = (r1 == 0) ? '0 : ref_mem[r1];
    e.b = (u && r2 != 0) ? ref_mem[r2] : '0;
    return e;
  endfunction

  task automatic rf_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    rf_we = 1; rf_write_addr = a; rf_din = d;
    step();
    rf_we = 0;
    if (a != 0) ref_mem[a] = d;
  endtask

  task automatic drive_req(input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic u);
    req_rs1 = r1; req_rs2 = r2; req_use_rs2 = u; req_valid = 1;
  endtask

  // Returns at the negedge before the accepting posedge
  task automatic wait_accept(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
      step();
    end
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  // Returns at a negedge with op_valid high; lat counts posedges after the accept edge
  task automatic wait_valid(output int lat);
    bit got;
    got = 0; lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (op_valid) begin got = 1; break; end
      step();
      lat++;
    end
    if (!got) check("valid_timeout", 0, 1);
  endtask

  task automatic consume();
    step();
    op_ready = 1;
    step();
    op_ready = 0;
  endtask

  task automatic run_op(input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic u,
                        input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    bit ok;
    int lat;
    drive_req(r1, r2, u);
    wait_accept(ok);
    check("rd_addr_rs1", rf_read_addr, r1);
    if (ok) sb.push_back('{ea, eb});
    step();
    req_valid = 0;
    @(negedge clk);
    if (u) check("rd_addr_rs2", rf_read_addr, r2);
    check("valid_early", op_valid, 0);
    step();
    wait_valid(lat);
    check("latency", lat + 1, u ? 2 : 1);
    consume();
  endtask

  // Hold request and op_ready high; accepts alternate between request A and B
  task automatic stream(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic [AW-1:0] b1, input logic [AW-1:0] b2,
                        input logic u, input int n, input int gap);
    int k;
    int prev;
    k = 0; prev = 0;
    op_ready = 1;
    drive_req(a1, a2, u);
    for (int i = 0; i < 60 && k < n; i++) begin
      @(negedge clk);
      if (req_valid && req_ready) begin
        sb.push_back(exp_of(req_rs1, req_rs2, u));
        if (k > 0) begin
          check("accept_gap", cyc - prev, gap);
          check("b2b_consume", op_valid && op_ready, 1);
        end
        prev = cyc;
        k++;
        step();
        if (k % 2 == 1) drive_req(b1, b2, u);
        else drive_req(a1, a2, u);
      end else begin
        step();
      end
    end
    req_valid = 0;
    check("stream_count", k, n);
    repeat (5) step();
    op_ready = 0;
    check("stream_drained", op_valid, 0);
  endtask

  initial begin
    bit ok;
    int lat;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    rst = 1; flush = 0; req_valid = 0; req_rs1 = 0; req_rs2 = 0; req_use_rs2 = 0;
    op_ready = 0; rf_we = 0; rf_write_addr = 0; rf_din = 0;
    // Clear the regfile through its write port while held in reset
    for (int i = 0; i < 32; i++) begin
      rf_we = 1; rf_write_addr = AW'(i); rf_din = '0;
      @(posedge clk); #1;
    end
    rf_we = 0;
    check("rst_op_valid", op_valid, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    @(negedge clk);
    rst = 0;
    step();

    // 1: basic two-operand read
    rf_write(5, 32'h11);
    rf_write(6, 32'h22);
    run_op(5, 6, 1, 32'h11, 32'h22);

    // 2: x0 forced to zero, also when a write to x0 coincides with the read
    rf_write(0, 32'hDEAD);
    run_op(0, 0, 1, 0, 0);
    rf_we = 1; rf_write_addr = 0; rf_din = 32'hBEEF;
    run_op(0, 0, 1, 0, 0);
    rf_we = 0;

    // 3a: write to rs1 on the WAIT1 edge is snooped
    drive_req(5, 6, 1);
    wait_accept(ok);
    if (ok) sb.push_back('{32'h99, 32'h22});
    step();
    req_valid = 0;
    rf_write(5, 32'h99);
    wait_valid(lat);
    consume();

    // 3b: write to rs2 while parked in OUT refreshes op_b
    drive_req(5, 6, 1);
    wait_accept(ok);
    if (ok) sb.push_back('{32'h99, 32'h77});
    step();
    req_valid = 0;
    wait_valid(lat);
    check("out_op_b_before", op_b, 32'h22);
    rf_we = 1; rf_write_addr = 6; rf_din = 32'h77;
    step();
    rf_we = 0;
    ref_mem[6] = 32'h77;
    @(negedge clk);
    check("out_op_b_after", op_b, 32'h77);
    check("out_held_valid", op_valid, 1);
    consume();

    // 4: single operand, then two-cycle cadence
    rf_write(7, 32'h5);
    run_op(7, 6, 0, 32'h5, 0);
    stream(7, 6, 7, 6, 0, 4, 2);

    // 5: alternating two-operand requests, three-cycle cadence
    stream(5, 6, 7, 5, 1, 4, 3);

    // 6a: flush in WAIT2 drops the request; nothing is accepted in the flush cycle
    drive_req(5, 6, 1);
    wait_accept(ok);
    step();
    req_valid = 0;
    step();
    drive_req(7, 7, 1);
    op_ready = 1;
    flush = 1;
    @(negedge clk);
    check("flush_no_accept", req_ready, 0);
    step();
    flush = 0;
    req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_no_valid", op_valid, 0);
      step();
    end
    op_ready = 0;
    run_op(5, 6, 1, 32'h99, 32'h77);

    // 6b: asynchronous reset in WAIT1
    drive_req(5, 6, 1);
    wait_accept(ok);
    step();
    req_valid = 0;
    #2 rst = 1;
    #1;
    check("arst_op_valid", op_valid, 0);
    check("arst_op_a", op_a, 0);
    check("arst_op_b", op_b, 0);
    check("arst_rd_addr", rf_read_addr, 5);
    @(negedge clk);
    rst = 0;
    step();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("arst_no_valid", op_valid, 0);
      step();
    end
    run_op(6, 5, 1, 32'h77, 32'h99);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
